hazard_detect_unit: RTL and testbench
=====================================

Name: hazard_detect_unit

Overview:
- Producer side of the forwarding handshake: tracks in-flight register writes through EX/MEM/WB and generates registered data_hazard_mem / data_hazard_wb for the forwarding unit.
- Detects load-use hazards and drives the ID-stage stall / EX bubble request.
- Sits beside the ID/EX pipeline latch, fed by decode, advanced by the global pipeline enable.

Parameters:
- NSLOT, 3, in-flight tracking depth (EX, MEM, WB); fixed at 3, other values illegal.
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- pipe_en  input  1  global pipeline advance (cache hits); all state updates only when 1.
- flush  input  1  branch/jump flush of IF/ID; instruction in ID is not tracked.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  5  source reg A.
- id_rt  input  5  source reg B.
- id_uses_rs  input  1  rs is read.
- id_uses_rt  input  1  rt is read.
- id_wsel  input  5  destination reg.
- id_wen  input  1  instruction writes the register file.
- id_memread  input  1  instruction is a load.
- stall  output  1  hold PC and IF/ID; insert bubble into ID/EX (combinational).
- data_hazard_mem  output  1  EX-stage instruction needs the MEM-stage result.
- data_hazard_wb  output  1  EX-stage instruction needs the WB-stage result.
- hazard_cnt  output  CNT_W  load-use stalls taken (optional feature only).
- fwd_cnt  output  CNT_W  cycles with any forward hazard (optional feature only).

Behaviour:
- Slot = {valid, wsel, memread}; slots ex_s, mem_s, wb_s. Reset: all slots invalid, wsel 0; data_hazard_mem=0, data_hazard_wb=0; counters 0.
- match(s, r) = s.valid & s.wen-derived valid & (s.wsel == r) & (r != 0). Reg 0 never matches.
- src_hit(s) = (id_uses_rs & match(s,id_rs)) | (id_uses_rt & match(s,id_rt)).
- stall = id_valid & ex_s.memread & src_hit(ex_s). Combinational, no latency. Independent of pipe_en.
- On rising CLK with pipe_en=1:
  - wb_s <= mem_s; mem_s <= ex_s.
  - ex_s <= the ID instruction if id_valid & id_wen & !stall & !flush; otherwise an invalid bubble.
  - data_hazard_mem <= id_valid & !stall & !flush & src_hit(ex_s) & !ex_s.memread.
  - data_hazard_wb <= id_valid & !stall & !flush & src_hit(mem_s).
- pipe_en=0: every register holds, including slots and hazard outputs; stall continues to be evaluated.
- Hazard outputs therefore describe the instruction now in EX, one cycle after it leaves ID.
- Both hazard outputs may be 1 simultaneously. The forwarding unit gives MEM priority; this block does not arbitrate.
- A load followed by a dependent instruction gives 1 stall cycle (with pipe_en=1), then data_hazard_wb=1 on the following cycle.
- flush and stall together: flush wins for slot insertion (bubble); stall output still follows its equation.
- RST mid-operation clears all slots immediately; no spurious hazard after release.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: hazard_cnt increments on every pipe_en cycle with stall=1. fwd_cnt increments on every pipe_en cycle where either registered hazard output is 1. Both saturate at all-ones.
- Undefined: counter ports and logic absent.

Decomposition:
- cpu_types_pkg gains hazard_slot_t (packed struct valid, wsel regbits_t, memread) and HSLOTS=3. Reuse existing regbits_t.
- One natural sub-module: hazard_match (combinational slot vs. rs/rt comparator, instanced per slot).

Test Plan:
- add $3 in EX, then ID sub $4,$3,$5, pipe_en=1 -> next cycle data_hazard_mem=1, data_hazard_wb=0, stall=0.
- lw $2 in EX, ID add $6,$2,$7 -> stall=1 that cycle. Next cycle stall=0, bubble in EX. Following cycle data_hazard_wb=1, data_hazard_mem=0.
- Producer writes $0, consumer reads $0 -> no stall, both hazards 0.
- Dependency on both MEM ($3) and WB ($4) slots via rs/rt -> both hazard outputs 1 together.
- pipe_en=0 for 3 cycles mid-dependency -> outputs and slots frozen. The hazard appears on the first pipe_en=1 edge.
- flush=1 with dependent ID instruction -> no hazard next cycle. Assert RST during stall -> all outputs 0 asynchronously. With HAZARD_STATS_EN, 2 load-use stalls -> hazard_cnt=2.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index and hazard-tracking slot.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  localparam int HSLOTS = 3;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     memread;
  } hazard_slot_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one in-flight write slot against the ID-stage source registers.
import cpu_types_pkg::*;

module hazard_match (
  input  hazard_slot_t slot,
  input  regbits_t     rs,
  input  regbits_t     rt,
  input  logic         uses_rs,
  input  logic         uses_rt,
  output logic         hit
);

  logic match_rs;
  logic match_rt;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  always_comb begin
    match_rs = slot.valid & (slot.wsel == rs) & (rs != '0);
    match_rt = slot.valid & (slot.wsel == rt) & (rt != '0);
    hit      = (uses_rs & match_rs) | (uses_rt & match_rt);
  end

endmodule

// File: rtl/hazard_detect_unit.sv
// Tracks in-flight register writes (EX/MEM/WB), raises load-use stall and
// registered forwarding hazards. Statistics counters under HAZARD_STATS_EN.
import cpu_types_pkg::*;

module hazard_detect_unit #(
  parameter int NSLOT = HSLOTS
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pipe_en,
  input  logic             flush,
  input  logic             id_valid,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  regbits_t         id_wsel,
  input  logic             id_wen,
  input  logic             id_memread,
  output logic             stall,
  output logic             data_hazard_mem,
  output logic             data_hazard_wb
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] fwd_cnt
`endif
);

  // Slot 0 = EX, 1 = MEM, 2 = WB; only depth 3 is meaningful.
  hazard_slot_t slot_q [NSLOT];
  hazard_slot_t slot_d [NSLOT];
  logic         dh_mem_q, dh_mem_d;
  logic         dh_wb_q,  dh_wb_d;
  logic         ex_hit, mem_hit;
  logic         id_go;

  hazard_match u_match_ex (
    .slot    (slot_q[0]),
    .rs      (id_rs),
    .rt      (id_rt),
    .uses_rs (id_uses_rs),
    .uses_rt (id_uses_rt),
    .hit     (ex_hit)
  );

  hazard_match u_match_mem (
    .slot    (slot_q[1]),
    .rs      (id_rs),
    .rt      (id_rt),
    .uses_rs (id_uses_rs),
    .uses_rt (id_uses_rt),
    .hit     (mem_hit)
  );

  always_comb begin
    stall = id_valid & slot_q[0].memread & ex_hit;
    id_go = id_valid & ~stall & ~flush;
  end

  // Everything holds while the pipeline is frozen; stall stays live.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) slot_d[i] = slot_q[i];
    dh_mem_d = dh_mem_q;
    dh_wb_d  = dh_wb_q;
    if (pipe_en) begin
      for (int i = NSLOT - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
      slot_d[0] = '0;
      if (id_go && id_wen) begin
        slot_d[0].valid   = 1'b1;
        slot_d[0].wsel    = id_wsel;
        slot_d[0].memread = id_memread;
      end
      dh_mem_d = id_go & ex_hit & ~slot_q[0].memread;
      dh_wb_d  = id_go & mem_hit;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
      dh_mem_q <= 1'b0;
      dh_wb_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= slot_d[i];
      dh_mem_q <= dh_mem_d;
      dh_wb_q  <= dh_wb_d;
    end
  end

  assign data_hazard_mem = dh_mem_q;
  assign data_hazard_wb  = dh_wb_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q,    fwd_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    fwd_cnt_d    = fwd_cnt_q;
    if (pipe_en && stall && (hazard_cnt_q != '1))
      hazard_cnt_d = hazard_cnt_q + 1'b1;
    if (pipe_en && (dh_mem_q || dh_wb_q) && (fwd_cnt_q != '1))
      fwd_cnt_d = fwd_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hazard_cnt_q <= '0;
      fwd_cnt_q    <= '0;
    end else begin
      hazard_cnt_q <= hazard_cnt_d;
      fwd_cnt_q    <= fwd_cnt_d;
    end
  end

  assign hazard_cnt = hazard_cnt_q;
  assign fwd_cnt    = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench for hazard_detect_unit; counter checks when HAZARD_STATS_EN is set.
module tb_hazard_detect_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       pipe_en;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wsel;
  logic       id_uses_rs, id_uses_rt, id_wen, id_memread;
  logic       stall, data_hazard_mem, data_hazard_wb;
`ifdef HAZARD_STATS_EN
  logic [15:0] hazard_cnt, fwd_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  hazard_detect_unit dut (
    .CLK             (CLK),
    .RST             (RST),
    .pipe_en         (pipe_en),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_wsel         (id_wsel),
    .id_wen          (id_wen),
    .id_memread      (id_memread),
    .stall           (stall),
    .data_hazard_mem (data_hazard_mem),
    .data_hazard_wb  (data_hazard_wb)
`ifdef HAZARD_STATS_EN
    ,
    .hazard_cnt      (hazard_cnt),
    .fwd_cnt         (fwd_cnt)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one ID instruction; settles before returning so stall can be sampled.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] wsel,
                       input logic wen, input logic mr);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_wsel    = wsel;
    id_wen     = wen;
    id_memread = mr;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle3();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) step();
  endtask

  initial begin
    RST     = 1'b1;
    pipe_en = 1'b1;
    flush   = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    check("reset_stall", {15'd0, stall}, 16'd0);
    check("reset_dh_mem", {15'd0, data_hazard_mem}, 16'd0);
    check("reset_dh_wb", {15'd0, data_hazard_wb}, 16'd0);
`ifdef HAZARD_STATS_EN
    check("reset_hazard_cnt", hazard_cnt, 16'd0);
    check("reset_fwd_cnt", fwd_cnt, 16'd0);
`endif
    step();
    RST = 1'b0;
    step();

    // add $3,$1,$2 then sub $4,$3,$5: EX->MEM forward
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    check("alu_dep_stall", {15'd0, stall}, 16'd0);
    step();
    check("alu_dep_dh_mem", {15'd0, data_hazard_mem}, 16'd1);
    check("alu_dep_dh_wb", {15'd0, data_hazard_wb}, 16'd0);
    idle3();
    check("idle_dh_mem", {15'd0, data_hazard_mem}, 16'd0);

    // lw $2 then add $6,$2,$7: one stall, then WB forward
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    check("load_use_stall", {15'd0, stall}, 16'd1);
    step();
    check("load_use_stall_clear", {15'd0, stall}, 16'd0);
    check("load_use_bubble_dh_mem", {15'd0, data_hazard_mem}, 16'd0);
    check("load_use_bubble_dh_wb", {15'd0, data_hazard_wb}, 16'd0);
    step();
    check("load_use_dh_wb", {15'd0, data_hazard_wb}, 16'd1);
    check("load_use_dh_mem", {15'd0, data_hazard_mem}, 16'd0);
    idle3();

    // lw $14 then consumer reading only rt=$14
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd9, 5'd14, 1'b0, 1'b1, 5'd15, 1'b1, 1'b0);
    check("load_use_rt_stall", {15'd0, stall}, 16'd1);
    step();
    idle3();

    // lw $0 then read $0: never a dependency
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    check("reg0_stall", {15'd0, stall}, 16'd0);
    step();
    check("reg0_dh_mem", {15'd0, data_hazard_mem}, 16'd0);
    check("reg0_dh_wb", {15'd0, data_hazard_wb}, 16'd0);
    idle3();

    // add $4; add $3; sub $9,$3,$4 -> both hazards
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    step();
    check("both_dh_mem", {15'd0, data_hazard_mem}, 16'd1);
    check("both_dh_wb", {15'd0, data_hazard_wb}, 16'd1);
    idle3();

    // Freeze mid-dependency: hazard waits for the first enabled edge
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frozen_dh_mem", {15'd0, data_hazard_mem}, 16'd0);
    end
    pipe_en = 1'b1;
    step();
    check("unfrozen_dh_mem", {15'd0, data_hazard_mem}, 16'd1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    pipe_en = 1'b0;
    repeat (2) step();
    check("frozen_hold_dh_mem", {15'd0, data_hazard_mem}, 16'd1);
    pipe_en = 1'b1;
    idle3();

    // Flush suppresses tracking of the ID instruction
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_dh_mem", {15'd0, data_hazard_mem}, 16'd0);
    check("flush_dh_wb", {15'd0, data_hazard_wb}, 16'd0);
    idle3();

    // Reset during a stall with a hazard output raised
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0);
    check("pre_reset_stall", {15'd0, stall}, 16'd1);
    check("pre_reset_dh_mem", {15'd0, data_hazard_mem}, 16'd1);
`ifdef HAZARD_STATS_EN
    check("stats_hazard_cnt", hazard_cnt, 16'd2);
`endif
    RST = 1'b1;
    #1;
    check("async_reset_stall", {15'd0, stall}, 16'd0);
    check("async_reset_dh_mem", {15'd0, data_hazard_mem}, 16'd0);
    check("async_reset_dh_wb", {15'd0, data_hazard_wb}, 16'd0);
`ifdef HAZARD_STATS_EN
    check("async_reset_hazard_cnt", hazard_cnt, 16'd0);
    check("async_reset_fwd_cnt", fwd_cnt, 16'd0);
`endif
    #1;
    RST = 1'b0;
    step();
    check("post_reset_stall", {15'd0, stall}, 16'd0);
    check("post_reset_dh_mem", {15'd0, data_hazard_mem}, 16'd0);
    check("post_reset_dh_wb", {15'd0, data_hazard_wb}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
